// File: rtl/elevator_pkg.sv
// elevator_pkg: shared FSM states, travel direction and seven-segment codes for the SCAN elevator
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
endpackage

// File: rtl/elevator_tick_div.sv
// elevator_tick_div: free-running divider, one-cycle tick every TICK_DIV clocks
module elevator_tick_div #(
  parameter int TICK_DIV = 50000000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: N-floor SCAN elevator with latched call mask, timed door and hold.
// Define ELEV_SEG7_EN to add the registered active-low HEX0 floor display.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int FW         = $clog2(N_FLOORS),
  parameter int TICK_DIV   = 50000000,
  parameter int DOOR_TICKS = 3
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic                call_valid,
  input  logic [FW-1:0]       call_floor,
  input  logic                hold,
  output logic [FW-1:0]       cur_floor,
  output logic                dir_up,
  output logic                dir_down,
  output logic                door_open,
  output logic                arrive,
  output logic [N_FLOORS-1:0] pending
`ifdef ELEV_SEG7_EN
  ,
  output logic [6:0]          HEX0
`endif
);
  localparam int DW = DOOR_TICKS > 1 ? $clog2(DOOR_TICKS) : 1;
  localparam logic [N_FLOORS-1:0] ONE = N_FLOORS'(1);
  state_t state, state_nxt;
  dir_t last_dir, last_nxt;
  logic [FW-1:0] floor_nxt;
  logic [DW-1:0] door_cnt, door_nxt;
  logic [N_FLOORS-1:0] pending_nxt, set_mask, clr_mask;
  logic tick, step, above, below, here, call_here;
  elevator_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .tick(tick)
  );
  assign dir_up    = state == UP;
  assign dir_down  = state == DOWN;
  assign door_open = state == DOOR;
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above |= pending[i] && i > int'(cur_floor);
      below |= pending[i] && i < int'(cur_floor);
    end
    here      = pending[cur_floor];
    call_here = call_valid && call_floor == cur_floor;
    step      = tick && !hold;
    state_nxt = state;
    floor_nxt = cur_floor;
    last_nxt  = last_dir;
    door_nxt  = door_cnt;
    case (state)
      IDLE:
        if (!hold)
          state_nxt = here ? DOOR :
                      last_dir == DIR_UP ? (above ? UP : below ? DOWN : IDLE) :
                                           (below ? DOWN : above ? UP : IDLE);
      UP: begin
        last_nxt  = DIR_UP;
        state_nxt = here ? DOOR : !above ? IDLE : UP;
        if (!here && above && step) floor_nxt = cur_floor + 1'b1;
      end
      DOWN: begin
        last_nxt  = DIR_DOWN;
        state_nxt = here ? DOOR : !below ? IDLE : DOWN;
        if (!here && below && step) floor_nxt = cur_floor - 1'b1;
      end
      default:
        if (call_here) door_nxt = '0;
        else if (step) begin
          if (door_cnt == DW'(DOOR_TICKS - 1)) state_nxt = IDLE;
          else door_nxt = door_cnt + 1'b1;
        end
    endcase
    if (state_nxt == DOOR && state != DOOR) door_nxt = '0;
    // a call for the floor being served is swallowed by the clear
    clr_mask    = state_nxt == DOOR ? ONE << cur_floor : '0;
    set_mask    = call_valid && int'(call_floor) < N_FLOORS ? ONE << call_floor : '0;
    pending_nxt = (pending | set_mask) & ~clr_mask;
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      state     <= IDLE;
      cur_floor <= '0;
      pending   <= '0;
      last_dir  <= DIR_UP;
      door_cnt  <= '0;
      arrive    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_floor <= floor_nxt;
      pending   <= pending_nxt;
      last_dir  <= last_nxt;
      door_cnt  <= door_nxt;
      arrive    <= state_nxt == DOOR && state != DOOR;
    end
`ifdef ELEV_SEG7_EN
  logic [4:0] disp;
  logic [6:0] seg_nxt;
  always_comb begin
    disp = 5'(floor_nxt) + 5'd1;
    case (disp)
      5'd1:    seg_nxt = SEG_1;
      5'd2:    seg_nxt = SEG_2;
      5'd3:    seg_nxt = SEG_3;
      5'd4:    seg_nxt = SEG_4;
      5'd5:    seg_nxt = SEG_5;
      5'd6:    seg_nxt = SEG_6;
      5'd7:    seg_nxt = SEG_7;
      5'd8:    seg_nxt = SEG_8;
      5'd9:    seg_nxt = SEG_9;
      default: seg_nxt = SEG_DASH;
    endcase
  end
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) HEX0 <= SEG_1;
    else HEX0 <= seg_nxt;
  if (N_FLOORS > 16) begin : g_range_err
    $error("elevator_scan_ctrl: N_FLOORS must not exceed 16 with the display enabled");
  end
`endif
endmodule
